gpio_irq: RTL

Parametrised general-purpose I/O block with input synchronisation, per-bit rising/falling edge detection, sticky write-1-to-clear status and a level interrupt output. It is the successor of the basic GPIO block: same bus-slave attachment through `bus_to_ip`, same byte-wise register layout style, with synchronised readback and edge-event capture added. It sits on the 8-bit register bus beside other basil modules and drives or samples board-level I/O pins.

---
 rtl/gpio_irq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/gpio_irq.sv
`default_nettype none
// ============================================================================
// Module : gpio_irq
// GPIO with input synchroniser, per-bit edge capture, W1C status and level IRQ.
// Rev    : 1.0
// ============================================================================
module gpio_irq #(
  parameter int          BASEADDR     = 0,
  parameter int          HIGHADDR     = 0,
  parameter int          ABUSWIDTH    = 16,
  parameter int          IO_WIDTH     = 8,
  parameter logic [63:0] IO_DIRECTION = 64'h0,
  parameter logic [63:0] IO_TRI       = 64'h0,
  parameter int          SYNC_STAGES  = 2
) (
  input  wire logic                 BUS_CLK,
  input  wire logic                 BUS_RST,
  input  wire logic [ABUSWIDTH-1:0] BUS_ADD,
  input  wire logic [7:0]           BUS_DATA_IN,
  input  wire logic                 BUS_RD,
  input  wire logic                 BUS_WR,
  inout  wire       [IO_WIDTH-1:0]  IO,
  output logic                      CS_OUT,
  output logic [7:0]                DATA_OUT,
  output logic                      INTERRUPT
);

  localparam logic [7:0]           VERSION = 8'd1;
  localparam int                   c_B     = ((IO_WIDTH - 1) / 8) + 1;
  localparam int                   c_W     = 8 * c_B;
  localparam int                   c_ARM   = SYNC_STAGES + 1;
  localparam int                   c_AW    = $clog2(c_ARM + 1);
  localparam logic [ABUSWIDTH-1:0] c_BASE  = ABUSWIDTH'(BASEADDR);
  localparam logic [ABUSWIDTH-1:0] c_SPAN  = ABUSWIDTH'(HIGHADDR - BASEADDR);
  localparam logic [ABUSWIDTH-1:0] c_CFG   = ABUSWIDTH'(6 * c_B + 1);

  logic [ABUSWIDTH-1:0] w_off;
  logic                 w_rd;
  logic                 w_wr;
  logic                 w_ver_hit;
  logic                 w_cfg_hit;
  logic                 w_rst;
  logic [5:0][c_B-1:0]  w_bsel;
  logic [5:1][c_B-1:0]  w_wsel;
  logic [c_W-1:0]       w_ext [6];
  logic [7:0]           w_rdata;
  logic [IO_WIDTH-1:0]  w_in;
  logic [IO_WIDTH-1:0]  w_evt;
  logic                 w_armed;

  logic [IO_WIDTH-1:0]  r_sync [SYNC_STAGES];
  logic [IO_WIDTH-1:0]  r_prev;
  logic [IO_WIDTH-1:0]  r_out;
  logic [IO_WIDTH-1:0]  r_dir;
  logic [IO_WIDTH-1:0]  r_ren;
  logic [IO_WIDTH-1:0]  r_fen;
  logic [IO_WIDTH-1:0]  r_sts;
  logic                 r_irq_en;
  logic [c_AW-1:0]      r_arm;

  // Byte-lane write: only bits below IO_WIDTH exist, so unused top bits stay 0.
  function automatic logic [IO_WIDTH-1:0] f_wr(input logic [IO_WIDTH-1:0] cur,
                                               input logic [c_B-1:0]      sel,
                                               input logic [7:0]          d);
    logic [IO_WIDTH-1:0] v;
    v = cur;
    for (int i = 0; i < IO_WIDTH; i++) begin
      if (sel[i/8]) v[i] = d[i%8];
    end
    return v;
  endfunction

  assign w_off     = BUS_ADD - c_BASE;
  assign CS_OUT    = (w_off <= c_SPAN);
  assign w_rd      = CS_OUT & BUS_RD;
  assign w_wr      = CS_OUT & BUS_WR;
  assign w_ver_hit = (w_off == '0);
  assign w_cfg_hit = (w_off == c_CFG);
  assign w_rst     = BUS_RST | (w_wr & w_ver_hit);
  assign w_wsel    = w_wr ? w_bsel[5:1] : '0;

  // Lowest address of each block carries the most significant byte.
  always_comb begin
    w_bsel = '0;
    for (int k = 0; k < 6; k++) begin
      for (int b = 0; b < c_B; b++) begin
        if (w_off == ABUSWIDTH'(k * c_B + c_B - b)) w_bsel[k][b] = 1'b1;
      end
    end
  end

  assign w_in     = r_sync[SYNC_STAGES-1];
  assign w_ext[0] = c_W'(w_in);
  assign w_ext[1] = c_W'(r_out);
  assign w_ext[2] = c_W'(r_dir);
  assign w_ext[3] = c_W'(r_ren);
  assign w_ext[4] = c_W'(r_fen);
  assign w_ext[5] = c_W'(r_sts);

  always_comb begin
    w_rdata = 8'h00;
    if (w_ver_hit) w_rdata = VERSION;
    if (w_cfg_hit) w_rdata = {7'b0, r_irq_en};
    for (int k = 0; k < 6; k++) begin
      for (int b = 0; b < c_B; b++) begin
        if (w_bsel[k][b]) w_rdata = w_ext[k][8*b +: 8];
      end
    end
  end

  assign w_armed = (r_arm == c_AW'(c_ARM));
  assign w_evt   = w_armed ? ((w_in & ~r_prev & r_ren) | (~w_in & r_prev & r_fen))
                           : '0;

  always_ff @(posedge BUS_CLK) begin
    if (w_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev   <= '0;
      r_out    <= '0;
      r_dir    <= '0;
      r_ren    <= '0;
      r_fen    <= '0;
      r_sts    <= '0;
      r_irq_en <= 1'b0;
      r_arm    <= '0;
      DATA_OUT <= 8'h00;
    end else begin
      r_sync[0] <= IO;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev <= w_in;
      if (!w_armed) r_arm <= r_arm + c_AW'(1);
      r_out <= f_wr(r_out, w_wsel[1], BUS_DATA_IN);
      r_dir <= f_wr(r_dir, w_wsel[2], BUS_DATA_IN);
      r_ren <= f_wr(r_ren, w_wsel[3], BUS_DATA_IN);
      r_fen <= f_wr(r_fen, w_wsel[4], BUS_DATA_IN);
      // A new event on the same edge as a W1C keeps the bit set.
      r_sts <= (r_sts & ~f_wr('0, w_wsel[5], BUS_DATA_IN)) | w_evt;
      if (w_wr && w_cfg_hit) r_irq_en <= BUS_DATA_IN[0];
      if (w_rd) DATA_OUT <= w_rdata;
    end
  end

  assign INTERRUPT = r_irq_en & (|r_sts);

  for (genvar i = 0; i < IO_WIDTH; i++) begin : g_io
    if (IO_TRI[i]) begin : g_tri
      assign IO[i] = r_dir[i] ? r_out[i] : 1'bz;
    end else if (IO_DIRECTION[i]) begin : g_out
      assign IO[i] = r_out[i];
    end else begin : g_in
      assign IO[i] = 1'bz;
    end
  end

endmodule
`default_nettype wire
